// File: rtl/ram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_bist_pkg
// Purpose : Shared types and constants for the RAM march-test BIST controller.
//           FSM state encoding, march phase codes and the read-latency ceiling.
// Revision: 1.0  initial release
// ============================================================================
package ram_bist_pkg;

    // Highest RAM read latency the compare pipe and drain counter support
    localparam int MAX_RD_LAT = 4;
    localparam int DRAIN_CW   = $clog2(MAX_RD_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_W_UP  = 3'd1,
        ST_RW_R  = 3'd2,
        ST_RW_W  = 3'd3,
        ST_R_DN  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6,
        ST_FAIL  = 3'd7
    } state_t;

    // March element a state belongs to
    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_W_UP = 2'd1,
        PH_RW   = 2'd2,
        PH_R_DN = 2'd3
    } phase_t;

    function automatic phase_t state_phase(input state_t s);
        case (s)
            ST_W_UP:          return PH_W_UP;
            ST_RW_R, ST_RW_W: return PH_RW;
            ST_R_DN:          return PH_R_DN;
            default:          return PH_NONE;
        endcase
    endfunction

    // States in which a test is running (drain included)
    function automatic logic is_active(input state_t s);
        return (s == ST_W_UP) || (s == ST_RW_R) || (s == ST_RW_W) ||
               (s == ST_R_DN) || (s == ST_DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bist_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_bist_if
// Purpose : Single-port synchronous RAM access bundle.
// Ports   : we     - write enable       (master -> slave)
//           addr   - address            (master -> slave)
//           wdata  - write data         (master -> slave)
//           rdata  - read data          (slave  -> master)
// Revision: 1.0  initial release
// ============================================================================
interface ram_bist_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/ram_bist_cmp.sv
`default_nettype none
// ============================================================================
// Module  : ram_bist_cmp
// Purpose : RD_LAT-deep pipe of {valid, addr, expected} for outstanding reads,
//           compared against RAM read data when each entry emerges.
// Ports   : clk, rst_n   - clock / async active-low reset
//           flush_i      - drop all outstanding entries
//           push_i       - a read is on the RAM port this cycle
//           addr_i/exp_i - address and expected data of that read
//           rdata_i      - RAM read data
//           mismatch_o   - emerging entry disagrees with rdata_i
//           mm_addr_o    - address of the emerging entry
//           mm_data_o    - read data seen for that entry
// Revision: 1.0  initial release
// ============================================================================
module ram_bist_cmp #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          flush_i,
    input  wire logic          push_i,
    input  wire logic [AW-1:0] addr_i,
    input  wire logic [DW-1:0] exp_i,
    input  wire logic [DW-1:0] rdata_i,
    output logic               mismatch_o,
    output logic [AW-1:0]      mm_addr_o,
    output logic [DW-1:0]      mm_data_o
);

    logic          vld_q  [RD_LAT];
    logic [AW-1:0] addr_q [RD_LAT];
    logic [DW-1:0] exp_q  [RD_LAT];

    // Stage k holds a read issued k+1 cycles ago; the last stage lines up
    // with the cycle in which that read's data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i]  <= 1'b0;
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else begin
            vld_q[0]  <= push_i && !flush_i;
            addr_q[0] <= addr_i;
            exp_q[0]  <= exp_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1] && !flush_i;
                addr_q[i] <= addr_q[i-1];
                exp_q[i]  <= exp_q[i-1];
            end
        end
    end

    assign mismatch_o = vld_q[RD_LAT-1] && (rdata_i != exp_q[RD_LAT-1]);
    assign mm_addr_o  = addr_q[RD_LAT-1];
    assign mm_data_o  = rdata_i;

endmodule
`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_bist_ctrl
// Purpose : March BIST initiator for one synchronous single-port RAM.
//           W(P) up; R(P)W(~P) up; R(~P) down; then pass/fail report.
// Ports   : clk, rst_n            - clock / async active-low reset
//           start                 - request, accepted in IDLE/DONE/FAIL
//           busy, done, pass      - status (pass valid while done)
//           fail_addr, fail_data  - first mismatch address / read data
//           err_count             - mismatch count (0 unless counting build)
//           ram                   - RAM port bundle (master side)
// Config  : BIST_ERR_COUNT_EN - count mismatches and always run the full
//           march; otherwise the first mismatch aborts into FAIL.
// Revision: 1.0  initial release
// ============================================================================
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int            AW      = 8,
    parameter int            DW      = 8,
    parameter logic [DW-1:0] PATTERN = DW'(8'hA5),
    parameter int            RD_LAT  = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic [15:0]   err_count,
    ram_bist_if.master    ram
);

    localparam logic [AW-1:0]       ADDR_MAX   = '1;
    localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DRAIN_CW-1:0] drain_q, drain_d;
    logic                we_q, we_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic                seen_q;
    logic [AW-1:0]       fail_addr_q;
    logic [DW-1:0]       fail_data_q;

    logic                start_acc;
    logic                push;
    logic [DW-1:0]       exp_pat;
    logic                mismatch;
    logic [AW-1:0]       mm_addr;
    logic [DW-1:0]       mm_data;

    ram_bist_cmp #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (!busy),
        .push_i     (push),
        .addr_i     (addr_q),
        .exp_i      (exp_pat),
        .rdata_i    (ram.rdata),
        .mismatch_o (mismatch),
        .mm_addr_o  (mm_addr),
        .mm_data_o  (mm_data)
    );

    assign start_acc = start && !is_active(state_q);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            drain_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d = ST_W_UP;
                    addr_d  = '0;
                end
            end
            ST_W_UP: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = ST_RW_R;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            ST_RW_R: state_d = ST_RW_W;
            ST_RW_W: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = ST_R_DN;
                    addr_d  = ADDR_MAX;
                end else begin
                    state_d = ST_RW_R;
                    addr_d  = addr_q + AW'(1);
                end
            end
            ST_R_DN: begin
                if (addr_q == '0) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q - AW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = ST_DONE;
                else                       drain_d = drain_q + DRAIN_CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
`ifndef BIST_ERR_COUNT_EN
        // Abort wins over every other transition, including DRAIN -> DONE
        if (mismatch && is_active(state_q)) state_d = ST_FAIL;
`endif
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy    = is_active(state_q);
        done    = (state_q == ST_DONE) || (state_q == ST_FAIL);
        pass    = (state_q == ST_DONE) && !seen_q;
        push    = (state_q == ST_RW_R) || (state_q == ST_R_DN);
        exp_pat = (state_phase(state_q) == PH_RW) ? PATTERN : ~PATTERN;
        // RAM controls are registered from the upcoming state so they line
        // up with the address register on the same edge.
        we_d    = (state_d == ST_W_UP) || (state_d == ST_RW_W);
        wdata_d = wdata_q;
        if (state_d == ST_W_UP)      wdata_d = PATTERN;
        else if (state_d == ST_RW_W) wdata_d = ~PATTERN;
    end

    // ---------------------------------------------------------------- results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (start_acc) begin
            seen_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (mismatch && busy && !seen_q) begin
            seen_q      <= 1'b1;
            fail_addr_q <= mm_addr;
            fail_data_q <= mm_data;
        end
    end

`ifdef BIST_ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (start_acc) begin
            err_cnt_q <= '0;
        end else if (mismatch && busy && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign ram.we    = we_q;
    assign ram.addr  = addr_q;
    assign ram.wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_bist_ctrl
// Purpose : Directed bench for ram_bist_ctrl: a latency-1 RAM with an optional
//           stuck-at-0 cell and a fault-free latency-3 RAM, each on its own DUT.
// Revision: 1.0  initial release
// ============================================================================
module tb_ram_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start3 = 1'b0;
    logic fault_en = 1'b0;

    always #5 clk = ~clk;

    logic        busy, done, pass, busy3, done3, pass3;
    logic [7:0]  fail_addr, fail_data, fail_addr3, fail_data3;
    logic [15:0] err_count, err_count3;

    ram_bist_if #(.AW(8), .DW(8)) bus1 ();
    ram_bist_if #(.AW(8), .DW(8)) bus3 ();

    ram_bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data),
        .err_count(err_count), .ram(bus1)
    );

    ram_bist_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .pass(pass3), .fail_addr(fail_addr3), .fail_data(fail_data3),
        .err_count(err_count3), .ram(bus3)
    );

    // Latency-1 RAM; cell 3C bit 0 stuck at 0 while fault_en is set
    logic [7:0] mem1 [256];
    always @(posedge clk) begin
        if (bus1.we)
            mem1[bus1.addr] <= (fault_en && bus1.addr == 8'h3C) ? (bus1.wdata & 8'hFE) : bus1.wdata;
        bus1.rdata <= mem1[bus1.addr];
    end

    // Latency-3 RAM, fault-free
    logic [7:0] mem3 [256];
    logic [7:0] r3a, r3b;
    always @(posedge clk) begin
        if (bus3.we) mem3[bus3.addr] <= bus3.wdata;
        r3a        <= mem3[bus3.addr];
        r3b        <= r3a;
        bus3.rdata <= r3b;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic wait_done1(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
    endtask

    task automatic wait_done3(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done3 && n < 3000);
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if ({busy, done, pass, bus1.we} !== 4'b0000) begin nerr++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, bus1.we}); end
        nvec++; if ({fail_addr, fail_data} !== 16'h0000) begin nerr++; $display("FAIL reset_fail_regs: got %h want 0000", {fail_addr, fail_data}); end
        nvec++; if (err_count !== 16'h0000) begin nerr++; $display("FAIL reset_err_count: got %h want 0000", err_count); end
        nvec++; if ({bus1.addr, bus1.wdata} !== 16'h0000) begin nerr++; $display("FAIL reset_ram_bus: got %h want 0000", {bus1.addr, bus1.wdata}); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_fault_free;
        int n;
        pulse_start();
        nvec++; if ({busy, done} !== 2'b10) begin nerr++; $display("FAIL ff_busy_rise: got busy,done=%b want 10", {busy, done}); end
        nvec++; if ({bus1.we, bus1.addr, bus1.wdata} !== {1'b1, 8'h00, 8'hA5}) begin nerr++; $display("FAIL ff_first_write: got %h want 100a5", {bus1.we, bus1.addr, bus1.wdata}); end
        wait_done1(n);
        nvec++; if (n != 1025) begin nerr++; $display("FAIL ff_duration: got %0d want 1025", n); end
        nvec++; if ({busy, pass} !== 2'b01) begin nerr++; $display("FAIL ff_pass: got busy,pass=%b want 01", {busy, pass}); end
        nvec++; if ({fail_addr, fail_data, err_count} !== 32'h0) begin nerr++; $display("FAIL ff_fail_regs: got %h want 0", {fail_addr, fail_data, err_count}); end
    endtask

    task automatic test_stuck_fault;
        int n;
        int exp_n;
        logic [15:0] exp_cnt;
`ifdef BIST_ERR_COUNT_EN
        exp_n   = 1025;
        exp_cnt = 16'd1;
`else
        // W_UP 256 cycles, read of 3C at 256+2*60, data back 1 later, FAIL next edge
        exp_n   = 378;
        exp_cnt = 16'd0;
`endif
        fault_en = 1'b1;
        pulse_start();
        wait_done1(n);
        nvec++; if (n != exp_n) begin nerr++; $display("FAIL sa0_duration: got %0d want %0d", n, exp_n); end
        nvec++; if ({busy, pass} !== 2'b00) begin nerr++; $display("FAIL sa0_pass: got busy,pass=%b want 00", {busy, pass}); end
        nvec++; if (fail_addr !== 8'h3C) begin nerr++; $display("FAIL sa0_fail_addr: got %h want 3c", fail_addr); end
        nvec++; if (fail_data !== 8'hA4) begin nerr++; $display("FAIL sa0_fail_data: got %h want a4", fail_data); end
        nvec++; if (err_count !== exp_cnt) begin nerr++; $display("FAIL sa0_err_count: got %h want %h", err_count, exp_cnt); end
        nvec++; if (bus1.we !== 1'b0) begin nerr++; $display("FAIL sa0_we_idle: got %b want 0", bus1.we); end
        fault_en = 1'b0;
    endtask

    task automatic test_rd_lat3;
        int n;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        nvec++; if (busy3 !== 1'b1) begin nerr++; $display("FAIL lat3_busy: got %b want 1", busy3); end
        wait_done3(n);
        nvec++; if (n != 1027) begin nerr++; $display("FAIL lat3_duration: got %0d want 1027", n); end
        nvec++; if (pass3 !== 1'b1) begin nerr++; $display("FAIL lat3_pass: got %b want 1", pass3); end
        nvec++; if ({fail_addr3, fail_data3} !== 16'h0) begin nerr++; $display("FAIL lat3_fail_regs: got %h want 0000", {fail_addr3, fail_data3}); end
    endtask

    task automatic test_reset_mid;
        int n;
        pulse_start();
        repeat (299) @(negedge clk);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if ({busy, done, pass, bus1.we} !== 4'b0000) begin nerr++; $display("FAIL mid_async_flags: got %b want 0000", {busy, done, pass, bus1.we}); end
        nvec++; if ({bus1.addr, bus1.wdata, fail_addr} !== 24'h0) begin nerr++; $display("FAIL mid_async_bus: got %h want 000000", {bus1.addr, bus1.wdata, fail_addr}); end
        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        wait_done1(n);
        nvec++; if (n != 1025 || pass !== 1'b1) begin nerr++; $display("FAIL mid_rerun: got cycles=%0d pass=%b want 1025 1", n, pass); end
    endtask

    task automatic test_start_held;
        int n;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        nvec++; if ({busy, done} !== 2'b10) begin nerr++; $display("FAIL held_accept: got busy,done=%b want 10", {busy, done}); end
        wait_done1(n);
        start = 1'b0;
        nvec++; if (n != 1025 || pass !== 1'b1) begin nerr++; $display("FAIL held_single_run: got cycles=%0d pass=%b want 1025 1", n, pass); end
        @(negedge clk);
        nvec++; if ({busy, done, pass} !== 3'b011) begin nerr++; $display("FAIL held_done_stays: got %b want 011", {busy, done, pass}); end
        pulse_start();
        nvec++; if ({busy, done, pass} !== 3'b100) begin nerr++; $display("FAIL restart_clears: got %b want 100", {busy, done, pass}); end
        wait_done1(n);
        nvec++; if (n != 1025 || pass !== 1'b1) begin nerr++; $display("FAIL restart_run: got cycles=%0d pass=%b want 1025 1", n, pass); end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_fault();
        test_rd_lat3();
        test_reset_mid();
        test_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
